mem_traffic_gen: RTL and testbench

Parametrised successor to the key-driven DDR3 burst tester. Drives the same burst-request interface of the AXI master: it writes pattern data, reads it back, checks it beat by beat and steps the address. Control comes from debounced PL keys or a free-running auto-loop mode. It adds selectable data patterns, an error counter, first-fail capture and address wrap.

---
 rtl/mem_test_pkg.sv | 41 ++++
 rtl/key_debounce.sv | 42 ++++
 rtl/mem_traffic_gen.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_traffic_gen.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_test_pkg.sv
// Shared encodings and the data-pattern generator used by the memory traffic generator
// for both write data and read-back checking.
package mem_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_READ     = 3'd2,
    ST_ADDR     = 3'd3,
    ST_WAIT_CLR = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PAT_ADDR     = 2'd0,
    PAT_BYTE     = 2'd1,
    PAT_WALK     = 2'd2,
    PAT_INV_ADDR = 2'd3
  } pat_e;

  localparam int unsigned PAT_MAX_BITS = 512;
  localparam int unsigned PAT_IDX_BITS = $clog2(PAT_MAX_BITS);

  // Word for one beat; callers truncate to their data width (<= PAT_MAX_BITS).
  function automatic logic [PAT_MAX_BITS-1:0] pattern(input logic [31:0] addr,
                                                      input logic [9:0]  beat,
                                                      input pat_e        sel,
                                                      input int unsigned data_bits);
    logic [PAT_MAX_BITS-1:0] word;
    logic [31:0]             a;
    a    = addr + 32'(beat) * 32'(data_bits / 8);
    word = '0;
    case (sel)
      PAT_ADDR: for (int i = 0; i < PAT_MAX_BITS / 32; i++) word[i*32 +: 32] = a;
      PAT_BYTE: for (int i = 0; i < PAT_MAX_BITS / 8; i++) word[i*8 +: 8] = beat[7:0];
      PAT_WALK: word[PAT_IDX_BITS'(32'(beat) % data_bits)] = 1'b1;
      PAT_INV_ADDR: for (int i = 0; i < PAT_MAX_BITS / 32; i++) word[i*32 +: 32] = ~a;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low key conditioner: 2-FF synchroniser, stability counter, and a one-cycle
// pulse when a new low level has been accepted.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic mem_clk,
  input  logic rst_n,
  input  logic key_n,
  output logic fall_pulse
);

  localparam int unsigned CNT_BITS = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]          key_sync;
  logic                level;
  logic [CNT_BITS-1:0] cnt;
  logic                accept;

  // New level is taken on the DEBOUNCE_CYCLES-th consecutive differing sample.
  assign accept = (key_sync[1] != level) && (cnt == CNT_BITS'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      key_sync   <= 2'b11;
      level      <= 1'b1;
      cnt        <= '0;
      fall_pulse <= 1'b0;
    end else begin
      key_sync   <= {key_sync[0], key_n};
      fall_pulse <= accept && !key_sync[1];
      if (key_sync[1] == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= key_sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/mem_traffic_gen.sv
// Burst-request traffic generator: writes a selectable pattern, reads it back, counts
// mismatches and steps/wraps the burst address under key or auto-loop control.
module mem_traffic_gen
  import mem_test_pkg::*;
#(
  parameter int unsigned MEM_DATA_BITS   = 64,
  parameter int unsigned ADDR_BITS       = 32,
  parameter int unsigned BURST_LEN       = 128,
  parameter int unsigned INI_ADDR        = 32'h0200_0000,
  parameter int unsigned ADDR_INC        = 1024,
  parameter int unsigned ADDR_LIMIT      = 32'h0400_0000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                     mem_clk,
  input  logic                     rst_n,
  input  logic                     pl_key1,
  input  logic                     pl_key2,
  input  logic                     pl_key3,
  input  logic                     pl_key4,
  input  logic                     auto_mode,
  input  logic [1:0]               pattern_sel,
  output logic                     wr_burst_req,
  output logic                     rd_burst_req,
  output logic [9:0]               wr_burst_len,
  output logic [9:0]               rd_burst_len,
  output logic [ADDR_BITS-1:0]     wr_burst_addr,
  output logic [ADDR_BITS-1:0]     rd_burst_addr,
  input  logic                     wr_burst_data_req,
  output logic [MEM_DATA_BITS-1:0] wr_burst_data,
  input  logic                     wr_burst_finish,
  input  logic                     rd_burst_finish,
  input  logic                     rd_burst_data_valid,
  input  logic [MEM_DATA_BITS-1:0] rd_burst_data,
  output logic                     error,
  output logic [15:0]              err_cnt,
  output logic [ADDR_BITS-1:0]     fail_addr,
  output logic [2:0]               state_debug
);

  localparam int unsigned AW_X = ADDR_BITS + 1;
  localparam logic [ADDR_BITS-1:0] INI          = ADDR_BITS'(INI_ADDR);
  localparam logic [ADDR_BITS:0]   ADDR_INC_X   = AW_X'(ADDR_INC);
  localparam logic [ADDR_BITS:0]   ADDR_LIMIT_X = AW_X'(ADDR_LIMIT);

  logic [3:0] key_n;
  logic [3:0] cmd;
  logic       cmd_clr, cmd_wr, cmd_rd, cmd_adv;

  assign key_n = {pl_key4, pl_key3, pl_key2, pl_key1};

  for (genvar g = 0; g < 4; g++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_debounce (
      .mem_clk   (mem_clk),
      .rst_n     (rst_n),
      .key_n     (key_n[g]),
      .fall_pulse(cmd[g])
    );
  end

  assign cmd_clr = cmd[0];
  assign cmd_wr  = cmd[1];
  assign cmd_rd  = cmd[2];
  assign cmd_adv = cmd[3];

  state_e                   state, state_d;
  pat_e                     pat, pat_d;
  logic [9:0]               wr_cnt, wr_cnt_d, rd_cnt, rd_cnt_d;
  logic                     wr_req_d, rd_req_d, error_d;
  logic [ADDR_BITS-1:0]     wr_addr_d, rd_addr_d, fail_addr_d, next_addr;
  logic [ADDR_BITS:0]       addr_sum;
  logic [MEM_DATA_BITS-1:0] wr_data_d, wr_pat, rd_pat;
  logic [15:0]              err_cnt_d;
  logic                     soft_clr, start_wr, start_rd;

  assign wr_burst_len = 10'(BURST_LEN);
  assign rd_burst_len = 10'(BURST_LEN);
  assign state_debug  = state;

  assign addr_sum  = {1'b0, wr_burst_addr} + ADDR_INC_X;
  assign next_addr = (addr_sum >= ADDR_LIMIT_X) ? INI : addr_sum[ADDR_BITS-1:0];

  assign wr_pat = MEM_DATA_BITS'(pattern(32'(wr_burst_addr), wr_cnt, pat, MEM_DATA_BITS));
  assign rd_pat = MEM_DATA_BITS'(pattern(32'(rd_burst_addr), rd_cnt, pat, MEM_DATA_BITS));

  // Next-state and next-output logic; a clear overrides everything except the debouncers.
  always_comb begin
    state_d     = state;
    pat_d       = pat;
    wr_req_d    = wr_burst_req;
    rd_req_d    = rd_burst_req;
    wr_addr_d   = wr_burst_addr;
    rd_addr_d   = rd_burst_addr;
    wr_data_d   = wr_burst_data;
    wr_cnt_d    = wr_cnt;
    rd_cnt_d    = rd_cnt;
    error_d     = error;
    err_cnt_d   = err_cnt;
    fail_addr_d = fail_addr;
    soft_clr    = 1'b0;
    start_wr    = 1'b0;
    start_rd    = 1'b0;

    if (wr_burst_data_req) begin
      wr_data_d = wr_pat;
      wr_cnt_d  = wr_cnt + 10'd1;
    end

    if ((state == ST_READ) && rd_burst_data_valid) begin
      rd_cnt_d = rd_cnt + 10'd1;
      if (rd_burst_data != rd_pat) begin
        error_d = 1'b1;
        if (err_cnt != 16'hFFFF) err_cnt_d = err_cnt + 16'd1;
        if (!error) fail_addr_d = rd_burst_addr;
      end
    end

    case (state)
      ST_IDLE: begin
        if (cmd_clr)        soft_clr = 1'b1;
        else if (cmd_wr)    start_wr = 1'b1;
        else if (cmd_rd)    start_rd = 1'b1;
        else if (cmd_adv)   state_d  = ST_ADDR;
        else if (auto_mode) start_wr = 1'b1;
      end
      ST_WRITE: begin
        if (wr_burst_finish) begin
          wr_req_d = 1'b0;
          wr_cnt_d = '0;
          state_d  = ST_IDLE;
          if (cmd_clr)        soft_clr = 1'b1;
          else if (auto_mode) start_rd = 1'b1;
        end else if (cmd_clr) begin
          state_d = ST_WAIT_CLR;
        end
      end
      ST_READ: begin
        if (rd_burst_finish) begin
          rd_req_d = 1'b0;
          rd_cnt_d = '0;
          state_d  = auto_mode ? ST_ADDR : ST_IDLE;
          if (cmd_clr) soft_clr = 1'b1;
        end else if (cmd_clr) begin
          state_d = ST_WAIT_CLR;
        end
      end
      ST_ADDR: begin
        if (cmd_clr) begin
          soft_clr = 1'b1;
        end else begin
          wr_addr_d = next_addr;
          state_d   = ST_IDLE;
          start_wr  = auto_mode;
        end
      end
      ST_WAIT_CLR: begin
        // Hold the request until the master closes the burst it already accepted.
        if ((wr_burst_req && wr_burst_finish) || (rd_burst_req && rd_burst_finish))
          soft_clr = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_wr) begin
      state_d  = ST_WRITE;
      wr_req_d = 1'b1;
      wr_cnt_d = '0;
      pat_d    = pat_e'(pattern_sel);
    end
    if (start_rd) begin
      state_d   = ST_READ;
      rd_req_d  = 1'b1;
      rd_cnt_d  = '0;
      rd_addr_d = wr_burst_addr;
    end

    if (soft_clr) begin
      state_d     = ST_IDLE;
      pat_d       = PAT_ADDR;
      wr_req_d    = 1'b0;
      rd_req_d    = 1'b0;
      wr_addr_d   = INI;
      rd_addr_d   = INI;
      wr_data_d   = '0;
      wr_cnt_d    = '0;
      rd_cnt_d    = '0;
      error_d     = 1'b0;
      err_cnt_d   = '0;
      fail_addr_d = '0;
    end
  end

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      pat           <= PAT_ADDR;
      wr_burst_req  <= 1'b0;
      rd_burst_req  <= 1'b0;
      wr_burst_addr <= INI;
      rd_burst_addr <= INI;
      wr_burst_data <= '0;
      wr_cnt        <= '0;
      rd_cnt        <= '0;
      error         <= 1'b0;
      err_cnt       <= '0;
      fail_addr     <= '0;
    end else begin
      state         <= state_d;
      pat           <= pat_d;
      wr_burst_req  <= wr_req_d;
      rd_burst_req  <= rd_req_d;
      wr_burst_addr <= wr_addr_d;
      rd_burst_addr <= rd_addr_d;
      wr_burst_data <= wr_data_d;
      wr_cnt        <= wr_cnt_d;
      rd_cnt        <= rd_cnt_d;
      error         <= error_d;
      err_cnt       <= err_cnt_d;
      fail_addr     <= fail_addr_d;
    end
  end

endmodule

// File: tb/tb_mem_traffic_gen.sv
// Randomised bench for mem_traffic_gen: a behavioural burst master and a pattern/error
// reference model built from the pattern rules, with a shortened debounce and address window.
module tb_mem_traffic_gen;

  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 32;
  localparam int unsigned BL    = 128;
  localparam int unsigned DEB   = 8;
  localparam int unsigned INC   = 1024;
  localparam logic [31:0] INI   = 32'h0200_0000;
  localparam logic [31:0] LIMIT = 32'h0200_0000 + 32'd6 * 32'd1024;

  logic          mem_clk = 1'b0;
  logic          rst_n;
  logic [4:1]    key;
  logic          auto_mode;
  logic [1:0]    pattern_sel;
  logic          wr_burst_req, rd_burst_req;
  logic [9:0]    wr_burst_len, rd_burst_len;
  logic [AW-1:0] wr_burst_addr, rd_burst_addr, fail_addr;
  logic          wr_burst_data_req, wr_burst_finish, rd_burst_finish, rd_burst_data_valid;
  logic [DW-1:0] wr_burst_data, rd_burst_data;
  logic          error;
  logic [15:0]   err_cnt;
  logic [2:0]    state_debug;

  int            checks = 0;
  int            errors = 0;

  // Reference-model state
  logic [31:0]   wr_addr_m;
  int            sel_m;
  bit            exp_err;
  int            exp_cnt;
  logic [31:0]   exp_fail;

  always #5 mem_clk = ~mem_clk;

  mem_traffic_gen #(
    .MEM_DATA_BITS  (DW),
    .ADDR_BITS      (AW),
    .BURST_LEN      (BL),
    .INI_ADDR       (INI),
    .ADDR_INC       (INC),
    .ADDR_LIMIT     (LIMIT),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .mem_clk            (mem_clk),
    .rst_n              (rst_n),
    .pl_key1            (key[1]),
    .pl_key2            (key[2]),
    .pl_key3            (key[3]),
    .pl_key4            (key[4]),
    .auto_mode          (auto_mode),
    .pattern_sel        (pattern_sel),
    .wr_burst_req       (wr_burst_req),
    .rd_burst_req       (rd_burst_req),
    .wr_burst_len       (wr_burst_len),
    .rd_burst_len       (rd_burst_len),
    .wr_burst_addr      (wr_burst_addr),
    .rd_burst_addr      (rd_burst_addr),
    .wr_burst_data_req  (wr_burst_data_req),
    .wr_burst_data      (wr_burst_data),
    .wr_burst_finish    (wr_burst_finish),
    .rd_burst_finish    (rd_burst_finish),
    .rd_burst_data_valid(rd_burst_data_valid),
    .rd_burst_data      (rd_burst_data),
    .error              (error),
    .err_cnt            (err_cnt),
    .fail_addr          (fail_addr),
    .state_debug        (state_debug)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_pat(input logic [31:0] base, input int beat, input int sel);
    int          b;
    logic [31:0] a;
    b = beat % 1024;
    a = base + 32'(b * int'(DW / 8));
    case (sel)
      0:       return {a, a};
      1:       return {8{8'(b)}};
      2:       return 64'd1 << (b % int'(DW));
      default: return {~a, ~a};
    endcase
  endfunction

  function automatic logic [31:0] ref_next(input logic [31:0] addr);
    longint nxt;
    nxt = longint'(addr) + longint'(INC);
    return (nxt >= longint'(LIMIT)) ? INI : 32'(nxt);
  endfunction

  task automatic press(input int idx);
    key[idx] = 1'b0;
    repeat (2 * DEB) @(negedge mem_clk);
    key[idx] = 1'b1;
    repeat (2 * DEB) @(negedge mem_clk);
  endtask

  task automatic wait_req(input bit is_wr, input string tag);
    int n = 0;
    while (((is_wr ? wr_burst_req : rd_burst_req) !== 1'b1) && (n < 200)) begin
      @(negedge mem_clk);
      n++;
    end
    check(tag, is_wr ? wr_burst_req : rd_burst_req, 64'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"},   state_debug,   64'd0);
    check({tag, "_wr_req"},  wr_burst_req,  64'd0);
    check({tag, "_rd_req"},  rd_burst_req,  64'd0);
    check({tag, "_wr_addr"}, wr_burst_addr, INI);
    check({tag, "_rd_addr"}, rd_burst_addr, INI);
    check({tag, "_wdata"},   wr_burst_data, 64'd0);
    check({tag, "_error"},   error,         64'd0);
    check({tag, "_err_cnt"}, err_cnt,       64'd0);
    check({tag, "_fail"},    fail_addr,     64'd0);
  endtask

  task automatic wr_beats(input logic [31:0] base, input int sel, input int first, input int last);
    for (int b = first; b < last; b++) begin
      if ($urandom_range(0, 3) == 0) @(negedge mem_clk);
      wr_burst_data_req = 1'b1;
      @(negedge mem_clk);
      wr_burst_data_req = 1'b0;
      check($sformatf("wdata_b%0d", b), wr_burst_data, ref_pat(base, b, sel));
    end
  endtask

  task automatic wr_finish(input int exp_state);
    wr_burst_finish = 1'b1;
    @(negedge mem_clk);
    wr_burst_finish = 1'b0;
    check("wr_req_drop", wr_burst_req, 64'd0);
    check("wr_fin_state", state_debug, 64'(exp_state));
  endtask

  task automatic rd_beats(input logic [31:0] base, input int sel, input int n, input logic [255:0] bad);
    logic [63:0] d;
    for (int b = 0; b < n; b++) begin
      if ($urandom_range(0, 3) == 0) @(negedge mem_clk);
      d = ref_pat(base, b, sel);
      if (bad[b]) begin
        d = d ^ (64'd1 << $urandom_range(0, 63));
        if (!exp_err) exp_fail = base;
        exp_err = 1'b1;
        exp_cnt++;
      end
      rd_burst_data_valid = 1'b1;
      rd_burst_data       = d;
      @(negedge mem_clk);
      rd_burst_data_valid = 1'b0;
    end
  endtask

  task automatic rd_finish(input int exp_state);
    rd_burst_finish = 1'b1;
    @(negedge mem_clk);
    rd_burst_finish = 1'b0;
    check("rd_req_drop", rd_burst_req, 64'd0);
    check("rd_fin_state", state_debug, 64'(exp_state));
  endtask

  task automatic check_err_model(input string tag);
    check({tag, "_error"},   error,     64'(exp_err));
    check({tag, "_err_cnt"}, err_cnt,   64'((exp_cnt > 65535) ? 65535 : exp_cnt));
    check({tag, "_fail"},    fail_addr, exp_fail);
  endtask

  initial begin
    logic [255:0] bad;
    rst_n = 1'b0; key = '1; auto_mode = 1'b0; pattern_sel = 2'd0;
    wr_burst_data_req = 1'b0; wr_burst_finish = 1'b0;
    rd_burst_finish = 1'b0; rd_burst_data_valid = 1'b0; rd_burst_data = '0;
    wr_addr_m = INI; sel_m = 0; exp_err = 1'b0; exp_cnt = 0; exp_fail = '0;
    repeat (3) @(negedge mem_clk);
    check_reset_vals("rst");
    check("rst_wr_len", wr_burst_len, 64'(BL));
    check("rst_rd_len", rd_burst_len, 64'(BL));
    rst_n = 1'b1;
    @(negedge mem_clk);

    // Bounces shorter than the debounce window must not produce a command
    for (int i = 0; i < 4; i++) begin
      key[2] = 1'b0; repeat (DEB - 3) @(negedge mem_clk);
      key[2] = 1'b1; repeat (3) @(negedge mem_clk);
    end
    repeat (2 * DEB) @(negedge mem_clk);
    check("bounce_state", state_debug, 64'd0);
    check("bounce_wr_req", wr_burst_req, 64'd0);

    // Key write, pattern 0
    press(2);
    wait_req(1'b1, "wr_req_rise");
    check("wr_state", state_debug, 64'd1);
    check("wr_addr", wr_burst_addr, wr_addr_m);
    wr_beats(wr_addr_m, sel_m, 0, BL);
    wr_finish(0);

    // Clean read-back, two beats beyond the burst length
    press(3);
    wait_req(1'b0, "rd_req_rise");
    check("rd_state", state_debug, 64'd2);
    check("rd_addr", rd_burst_addr, wr_addr_m);
    bad = '0;
    rd_beats(wr_addr_m, sel_m, BL + 2, bad);
    rd_finish(0);
    check_err_model("rd_clean");

    // Read with beats 5, 9, 10 corrupted
    press(3);
    wait_req(1'b0, "rd2_req_rise");
    bad = '0; bad[5] = 1'b1; bad[9] = 1'b1; bad[10] = 1'b1;
    rd_beats(wr_addr_m, sel_m, BL, bad);
    rd_finish(0);
    check_err_model("rd_bad3");

    // Random pattern at the next address; pattern_sel changes mid-burst must be ignored
    sel_m = int'($urandom_range(0, 3));
    pattern_sel = 2'(sel_m);
    press(4);
    wr_addr_m = ref_next(wr_addr_m);
    check("adv1_addr", wr_burst_addr, wr_addr_m);
    press(2);
    wait_req(1'b1, "wr3_req_rise");
    pattern_sel = 2'(sel_m ^ 1);
    wr_beats(wr_addr_m, sel_m, 0, BL);
    wr_finish(0);
    press(3);
    wait_req(1'b0, "rd3_req_rise");
    check("rd3_addr", rd_burst_addr, wr_addr_m);
    bad = '0;
    for (int k = 0; k < int'($urandom_range(1, 4)); k++) bad[$urandom_range(0, BL - 1)] = 1'b1;
    rd_beats(wr_addr_m, sel_m, BL, bad);
    rd_finish(0);
    check_err_model("rd_rand");

    // Clear in IDLE restores reset values
    press(1);
    wr_addr_m = INI; exp_err = 1'b0; exp_cnt = 0; exp_fail = '0;
    check_reset_vals("clr_idle");

    // Address advance with wrap at the limit
    for (int i = 0; i < 7; i++) begin
      press(4);
      wr_addr_m = ref_next(wr_addr_m);
      check($sformatf("adv_addr_%0d", i), wr_burst_addr, wr_addr_m);
      check($sformatf("adv_state_%0d", i), state_debug, 64'd0);
    end

    // Auto loop with walking-one pattern
    sel_m = 2; pattern_sel = 2'd2; auto_mode = 1'b1;
    for (int it = 0; it < 2; it++) begin
      wait_req(1'b1, "auto_wr_req");
      check("auto_wr_state", state_debug, 64'd1);
      check("auto_wr_addr", wr_burst_addr, wr_addr_m);
      wr_beats(wr_addr_m, sel_m, 0, BL);
      wr_finish(2);
      check("auto_rd_req", rd_burst_req, 64'd1);
      check("auto_rd_addr", rd_burst_addr, wr_addr_m);
      bad = '0;
      rd_beats(wr_addr_m, sel_m, BL, bad);
      if (it == 1) auto_mode = 1'b0;
      rd_finish((it == 1) ? 0 : 3);
      if (it == 0) begin
        wr_addr_m = ref_next(wr_addr_m);
        @(negedge mem_clk);
        check("auto_loop_state", state_debug, 64'd1);
        check("auto_loop_addr", wr_burst_addr, wr_addr_m);
      end
    end
    check_err_model("auto");

    // Clear mid-write waits for the burst to finish
    sel_m = int'($urandom_range(0, 3));
    pattern_sel = 2'(sel_m);
    press(2);
    wait_req(1'b1, "clrw_req_rise");
    wr_beats(wr_addr_m, sel_m, 0, BL / 2);
    press(1);
    check("clrw_state", state_debug, 64'd4);
    check("clrw_req_held", wr_burst_req, 64'd1);
    wr_beats(wr_addr_m, sel_m, BL / 2, BL);
    wr_finish(0);
    check_reset_vals("clr_mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
